// File: rtl/mod_seq_pkg.sv
// Shared sequencer state encoding, default geometry and derived frame lengths.
package mod_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int DEF_VOICES   = 8;
  localparam int DEF_V_OSC    = 4;
  localparam int DEF_O_ENVS   = 2;
  localparam int RUN_CYCLES   = DEF_VOICES * DEF_V_OSC * DEF_O_ENVS;
  localparam int DRAIN_CYCLES = DEF_V_OSC * DEF_O_ENVS + 1;
endpackage

// File: rtl/idx_delay_line.sv
// Enable-gated index shift chain; taps[0] takes the new index, taps[k] <- taps[k-1].
module idx_delay_line #(
  parameter int DEPTH = 31,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] idx,
  output logic [WIDTH-1:0] taps [DEPTH-1:0]
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) taps[k] <= '0;
    end else if (en) begin
      taps[0] <= idx;
      for (int k = 1; k < DEPTH; k++) taps[k] <= taps[k-1];
    end
  end

endmodule

// File: rtl/mod_matrix_sequencer.sv
// Frame slot scheduler for the modulation matrix: walks voice/osc/env indices, then drains.
// Optional overrun status counter is built when MOD_SEQ_OVERRUN_STATUS_EN is defined.
module mod_matrix_sequencer
  import mod_seq_pkg::*;
#(
  parameter int VOICES   = DEF_VOICES,
  parameter int V_OSC    = DEF_V_OSC,
  parameter int O_ENVS   = DEF_O_ENVS,
  parameter int V_ENVS   = V_OSC * O_ENVS,
  parameter int V_WIDTH  = 3,
  parameter int O_WIDTH  = 2,
  parameter int OE_WIDTH = 1,
  parameter int x_offset = V_OSC * VOICES - 2
) (
  input  logic                sCLK_XVXENVS,
  input  logic                reset,
  input  logic                enable,
  input  logic                frame_start,
  output logic                busy,
  output logic                frame_done,
  output logic                osc_ce,
  output logic [OE_WIDTH-1:0] env_idx,
  output logic [O_WIDTH-1:0]  osc_idx,
  output logic [V_WIDTH-1:0]  voice_idx,
  output logic [V_ENVS:0]     sh_osc_reg,
  output logic [V_OSC+2:0]    sh_voice_reg,
  output logic [O_WIDTH-1:0]  ox_dly [x_offset:0],
  output logic [V_WIDTH-1:0]  vx_dly [x_offset:0]
`ifdef MOD_SEQ_OVERRUN_STATUS_EN
  ,
  input  logic                overrun_clr,
  output logic [7:0]          overrun_cnt
`endif
);

  localparam int DC_W = $clog2(V_ENVS + 1);

  state_t              state, state_n;
  logic [OE_WIDTH-1:0] env_n;
  logic [O_WIDTH-1:0]  osc_n;
  logic [V_WIDTH-1:0]  voice_n;
  logic [DC_W-1:0]     drain_cnt, drain_n;
  logic                busy_n, done_n;
  logic                env_last, osc_last, voice_last, step;

  assign env_last   = (env_idx == OE_WIDTH'(O_ENVS - 1));
  assign osc_last   = (osc_idx == O_WIDTH'(V_OSC - 1));
  assign voice_last = (voice_idx == V_WIDTH'(VOICES - 1));
  assign step       = (state != IDLE) && enable;
  assign osc_ce     = step && env_last;

  always_ff @(posedge sCLK_XVXENVS or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      env_idx    <= '0;
      osc_idx    <= '0;
      voice_idx  <= '0;
      drain_cnt  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      env_idx    <= env_n;
      osc_idx    <= osc_n;
      voice_idx  <= voice_n;
      drain_cnt  <= drain_n;
      busy       <= busy_n;
      frame_done <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    env_n   = env_idx;
    osc_n   = osc_idx;
    voice_n = voice_idx;
    drain_n = drain_cnt;
    busy_n  = busy;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start && enable) begin
          state_n = RUN;
          busy_n  = 1'b1;
        end
      end
      RUN: begin
        if (enable) begin
          if (!env_last) begin
            env_n = env_idx + 1'b1;
          end else begin
            env_n = '0;
            if (!osc_last) begin
              osc_n = osc_idx + 1'b1;
            end else begin
              osc_n = '0;
              if (!voice_last) begin
                voice_n = voice_idx + 1'b1;
              end else begin
                voice_n = '0;
                drain_n = '0;
                state_n = DRAIN;
              end
            end
          end
        end
      end
      DRAIN: begin
        // Only env keeps cycling here; the drain counter times the flush window.
        if (enable) begin
          if (drain_cnt == DC_W'(V_ENVS)) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            env_n   = '0;
            drain_n = '0;
          end else begin
            drain_n = drain_cnt + 1'b1;
            env_n   = env_last ? '0 : env_idx + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sCLK_XVXENVS or posedge reset) begin
    if (reset) begin
      sh_osc_reg   <= '0;
      sh_voice_reg <= '0;
    end else begin
      if (step)
        sh_osc_reg <= {sh_osc_reg[V_ENVS-1:0], (state == RUN) && (env_idx == '0)};
      if (osc_ce)
        sh_voice_reg <= {sh_voice_reg[V_OSC+1:0], (state == RUN) && (osc_idx == '0)};
    end
  end

  idx_delay_line #(.DEPTH(x_offset + 1), .WIDTH(O_WIDTH)) u_ox_dly (
    .clk  (sCLK_XVXENVS),
    .rst  (reset),
    .en   (osc_ce),
    .idx  (osc_idx),
    .taps (ox_dly)
  );

  idx_delay_line #(.DEPTH(x_offset + 1), .WIDTH(V_WIDTH)) u_vx_dly (
    .clk  (sCLK_XVXENVS),
    .rst  (reset),
    .en   (osc_ce),
    .idx  (voice_idx),
    .taps (vx_dly)
  );

`ifdef MOD_SEQ_OVERRUN_STATUS_EN
  always_ff @(posedge sCLK_XVXENVS or posedge reset) begin
    if (reset)
      overrun_cnt <= '0;
    else if (overrun_clr)
      overrun_cnt <= '0;
    else if (frame_start && busy && (overrun_cnt != 8'hFF))
      overrun_cnt <= overrun_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_mod_matrix_sequencer.sv
// Randomised and directed bench for mod_matrix_sequencer against a frame-position model.
module tb_mod_matrix_sequencer;
  import mod_seq_pkg::*;

  localparam int NV   = DEF_VOICES;
  localparam int NO   = DEF_V_OSC;
  localparam int NE   = DEF_O_ENVS;
  localparam int XO   = NO * NV - 2;
  localparam int OXW  = (XO + 1) * 2;
  localparam int VXW  = (XO + 1) * 3;
  localparam int SNW  = 9 + (NO * NE + 1) + (NO + 3) + OXW + VXW;
  localparam int FRAME = RUN_CYCLES + DRAIN_CYCLES;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic fs  = 1'b0;
  logic clr = 1'b0;

  logic             busy, frame_done, osc_ce;
  logic [0:0]       env_idx;
  logic [1:0]       osc_idx;
  logic [2:0]       voice_idx;
  logic [NO*NE:0]   sh_osc_reg;
  logic [NO+2:0]    sh_voice_reg;
  logic [1:0]       ox_dly [XO:0];
  logic [2:0]       vx_dly [XO:0];
  logic [7:0]       overrun_cnt;

  int checks = 0;
  int errors = 0;

  // Model: frame position counts enabled steps since acceptance.
  bit             m_active, m_done;
  int             m_p, m_ovr;
  logic [NO*NE:0] m_sh_osc;
  logic [NO+2:0]  m_sh_voice;
  logic [OXW-1:0] m_ox;
  logic [VXW-1:0] m_vx;

  logic [OXW-1:0] ox_flat;
  logic [VXW-1:0] vx_flat;
  logic [SNW-1:0] dut_snap;

  mod_matrix_sequencer dut (
    .sCLK_XVXENVS (clk),
    .reset        (rst),
    .enable       (en),
    .frame_start  (fs),
    .busy         (busy),
    .frame_done   (frame_done),
    .osc_ce       (osc_ce),
    .env_idx      (env_idx),
    .osc_idx      (osc_idx),
    .voice_idx    (voice_idx),
    .sh_osc_reg   (sh_osc_reg),
    .sh_voice_reg (sh_voice_reg),
    .ox_dly       (ox_dly),
    .vx_dly       (vx_dly)
`ifdef MOD_SEQ_OVERRUN_STATUS_EN
    ,
    .overrun_clr  (clr),
    .overrun_cnt  (overrun_cnt)
`endif
  );

`ifndef MOD_SEQ_OVERRUN_STATUS_EN
  assign overrun_cnt = 8'd0;
`endif

  always #5 clk = ~clk;

  always_comb begin
    ox_flat = '0;
    vx_flat = '0;
    for (int k = 0; k <= XO; k++) begin
      ox_flat[k*2 +: 2] = ox_dly[k];
      vx_flat[k*3 +: 3] = vx_dly[k];
    end
  end

  assign dut_snap = {busy, frame_done, osc_ce, env_idx, osc_idx, voice_idx,
                     sh_osc_reg, sh_voice_reg, ox_flat, vx_flat};

  function automatic void idx_of(input int p, output int e, output int o, output int v);
    if (p < RUN_CYCLES) begin
      e = p % NE;
      o = (p / NE) % NO;
      v = p / (NE * NO);
    end else begin
      e = (p - RUN_CYCLES) % NE;
      o = 0;
      v = 0;
    end
  endfunction

  function automatic logic [SNW-1:0] exp_snap();
    int e, o, v;
    bit ce;
    idx_of(m_p, e, o, v);
    ce = m_active && en && (e == NE - 1);
    return {m_active, m_done, ce, 1'(e), 2'(o), 3'(v), m_sh_osc, m_sh_voice, m_ox, m_vx};
  endfunction

  task automatic model_reset();
    m_active = 0; m_done = 0; m_p = 0; m_ovr = 0;
    m_sh_osc = '0; m_sh_voice = '0; m_ox = '0; m_vx = '0;
  endtask

  task automatic model_step();
    int e, o, v;
    if (rst) begin
      model_reset();
    end else begin
      idx_of(m_p, e, o, v);
      if (clr) m_ovr = 0;
      else if (fs && m_active && m_ovr < 255) m_ovr++;
      m_done = 0;
      if (m_active && en) begin
        m_sh_osc = {m_sh_osc[NO*NE-1:0], (m_p < RUN_CYCLES) && (e == 0)};
        if (e == NE - 1) begin
          m_sh_voice = {m_sh_voice[NO+1:0], (m_p < RUN_CYCLES) && (o == 0)};
          m_ox = {m_ox[OXW-3:0], 2'(o)};
          m_vx = {m_vx[VXW-4:0], 3'(v)};
        end
        m_p++;
        if (m_p == FRAME) begin
          m_active = 0; m_p = 0; m_done = 1;
        end
      end else if (!m_active && fs && en) begin
        m_active = 1; m_p = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    logic [SNW-1:0] exp;
    rst = 1; en = 0; fs = 0; clr = 0;
    model_reset();
    #3;
    exp = exp_snap();
    checks++;
    if (dut_snap !== exp) begin
      errors++; $display("FAIL reset_state got %h exp %h", dut_snap, exp);
    end
    checks++;
    if (overrun_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_overrun got %0d exp 0", overrun_cnt);
    end
    en = 1; fs = 1;
    tick();
    exp = exp_snap();
    checks++;
    if (dut_snap !== exp) begin
      errors++; $display("FAIL reset_held_start got %h exp %h", dut_snap, exp);
    end
    @(negedge clk);
    rst = 0; fs = 0;
  endtask

  task automatic test_single_frame();
    int nbusy, ndone, nce;
    logic [SNW-1:0] exp;
    nbusy = 0; ndone = 0; nce = 0;
    en = 1; fs = 1;
    tick();
    fs = 0;
    for (int i = 0; i < FRAME + 12; i++) begin
      exp = exp_snap();
      checks++;
      if (dut_snap !== exp) begin
        errors++; $display("FAIL single_frame cyc %0d got %h exp %h", i, dut_snap, exp);
      end
      if (busy) nbusy++;
      if (frame_done) ndone++;
      if (osc_ce) nce++;
      tick();
    end
    checks++;
    if (nbusy != FRAME) begin errors++; $display("FAIL single_busy_len got %0d exp %0d", nbusy, FRAME); end
    checks++;
    if (ndone != 1) begin errors++; $display("FAIL single_done_cnt got %0d exp 1", ndone); end
    checks++;
    if (nce != NV * NO + NO) begin errors++; $display("FAIL single_osc_ce_cnt got %0d exp %0d", nce, NV * NO + NO); end
  endtask

  task automatic test_enable_freeze();
    int nbusy, nce;
    logic [SNW-1:0] exp;
    nbusy = 0; nce = 0;
    en = 1; fs = 1;
    tick();
    fs = 0;
    for (int i = 1; i <= FRAME + 15; i++) begin
      exp = exp_snap();
      checks++;
      if (dut_snap !== exp) begin
        errors++; $display("FAIL freeze cyc %0d got %h exp %h", i, dut_snap, exp);
      end
      if (busy) nbusy++;
      if (osc_ce) nce++;
      if (i == 20) en = 0;
      if (i == 25) en = 1;
      tick();
    end
    checks++;
    if (nbusy != FRAME + 5) begin errors++; $display("FAIL freeze_busy_len got %0d exp %0d", nbusy, FRAME + 5); end
    checks++;
    if (nce != NV * NO + NO) begin errors++; $display("FAIL freeze_osc_ce_cnt got %0d exp %0d", nce, NV * NO + NO); end
  endtask

  task automatic test_ignored_starts();
    int nbusy, ndone;
    logic [SNW-1:0] exp;
    nbusy = 0; ndone = 0;
    en = 1; fs = 1;
    tick();
    fs = 0;
    for (int i = 1; i <= FRAME + 12; i++) begin
      exp = exp_snap();
      checks++;
      if (dut_snap !== exp) begin
        errors++; $display("FAIL ignored cyc %0d got %h exp %h", i, dut_snap, exp);
      end
      if (busy) nbusy++;
      if (frame_done) ndone++;
      fs = (i == 10) || (i == FRAME);
      tick();
      fs = 0;
    end
    checks++;
    if (ndone != 1) begin errors++; $display("FAIL ignored_done_cnt got %0d exp 1", ndone); end
    checks++;
    if (nbusy != FRAME) begin errors++; $display("FAIL ignored_busy_len got %0d exp %0d", nbusy, FRAME); end
`ifdef MOD_SEQ_OVERRUN_STATUS_EN
    checks++;
    if (overrun_cnt !== 8'd2) begin errors++; $display("FAIL overrun_cnt got %0d exp 2", overrun_cnt); end
    clr = 1;
    tick();
    clr = 0;
    checks++;
    if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL overrun_clr got %0d exp 0", overrun_cnt); end
`endif
  endtask

  task automatic test_reset_midframe();
    int ndone, nbusy;
    logic [SNW-1:0] exp;
    ndone = 0; nbusy = 0;
    en = 1; fs = 1;
    tick();
    fs = 0;
    for (int i = 1; i < 30; i++) tick();
    #2 rst = 1;
    model_reset();
    #1;
    exp = exp_snap();
    checks++;
    if (dut_snap !== exp) begin
      errors++; $display("FAIL async_reset got %h exp %h", dut_snap, exp);
    end
    tick();
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (frame_done) ndone++;
    end
    checks++;
    if (ndone != 0) begin errors++; $display("FAIL reset_no_done got %0d exp 0", ndone); end
    fs = 1;
    tick();
    fs = 0;
    for (int i = 0; i < FRAME + 10; i++) begin
      exp = exp_snap();
      checks++;
      if (dut_snap !== exp) begin
        errors++; $display("FAIL post_reset cyc %0d got %h exp %h", i, dut_snap, exp);
      end
      if (busy) nbusy++;
      tick();
    end
    checks++;
    if (nbusy != FRAME) begin errors++; $display("FAIL post_reset_busy_len got %0d exp %0d", nbusy, FRAME); end
  endtask

  task automatic test_back_to_back();
    int nbusy;
    bit found;
    logic [SNW-1:0] exp;
    nbusy = 0; found = 0;
    en = 1; fs = 1;
    tick();
    fs = 0;
    for (int i = 0; i < 200; i++) begin
      if (frame_done) begin found = 1; break; end
      tick();
    end
    checks++;
    if (!found) begin errors++; $display("FAIL b2b_done_timeout got 0 exp 1"); end
    fs = 1;
    tick();
    fs = 0;
    for (int i = 0; i < FRAME + 10; i++) begin
      exp = exp_snap();
      checks++;
      if (dut_snap !== exp) begin
        errors++; $display("FAIL b2b cyc %0d got %h exp %h", i, dut_snap, exp);
      end
      if (busy) nbusy++;
      tick();
    end
    checks++;
    if (nbusy != FRAME) begin errors++; $display("FAIL b2b_busy_len got %0d exp %0d", nbusy, FRAME); end
  endtask

  task automatic test_random();
    logic [SNW-1:0] exp;
    for (int i = 0; i < 3000; i++) begin
      en  = ($urandom_range(0, 7) != 0);
      fs  = ($urandom_range(0, 5) == 0);
      clr = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 699) == 0);
      tick();
      exp = exp_snap();
      checks++;
      if (dut_snap !== exp) begin
        errors++; $display("FAIL random cyc %0d got %h exp %h", i, dut_snap, exp);
      end
`ifdef MOD_SEQ_OVERRUN_STATUS_EN
      checks++;
      if (overrun_cnt !== 8'(m_ovr)) begin
        errors++; $display("FAIL random_overrun cyc %0d got %0d exp %0d", i, overrun_cnt, m_ovr);
      end
`endif
    end
    rst = 0; fs = 0; clr = 0; en = 1;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_enable_freeze();
    test_ignored_starts();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
